mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory (IMEM/DMEM-style block RAM) between the core's instruction-fetch requester and its load/store requester.
- Grants at most one access per cycle. Data side has priority; an anti-starvation counter protects fetch.
- Tags each in-flight read so the read data is returned to the requester that issued it, MEM_LATENCY cycles later.
- Sits between the pipeline's fetch/memory stages and the RAM macro.

Parameters:
- AWIDTH, 14, word-address width.
- DWIDTH, 32, data width.
- MEM_LATENCY, 1, memory read latency in cycles; legal values 1..3.
- STARVE_LIMIT, 3, consecutive denied fetch cycles before fetch is forced to win; 0 disables the forcing.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request.
- if_addr  in  AWIDTH  fetch word address.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DWIDTH  fetch read data.
- d_req  in  1  data request.
- d_we  in  4  byte write enables; 0 means read.
- d_addr  in  AWIDTH  data word address.
- d_wdata  in  DWIDTH  store data.
- d_gnt  out  1  data accepted this cycle (combinational).
- d_rvalid  out  1  load data valid.
- d_rdata  out  DWIDTH  load data.
- mem_en  out  1  memory enable.
- mem_we  out  4  memory byte write enables.
- mem_addr  out  AWIDTH  memory address.
- mem_din  out  DWIDTH  memory write data.
- mem_dout  in  DWIDTH  memory read data, valid MEM_LATENCY cycles after mem_en.

Behaviour:
- Grant rule, combinational:
  - d_gnt = d_req && !force_if.
  - if_gnt = if_req && (!d_req || force_if).
  - force_if = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_LIMIT).
  - At most one grant per cycle.
- Memory drive, combinational:
  - mem_en = if_gnt || d_gnt.
  - If d_gnt: mem_addr = d_addr, mem_we = d_we, mem_din = d_wdata.
  - If if_gnt: mem_addr = if_addr, mem_we = 0.
  - With no grant: mem_addr = 0, mem_we = 0, mem_din = 0.
- starve_cnt (width clog2(STARVE_LIMIT+1), minimum 1 bit):
  - Increments when if_req && !if_gnt.
  - Clears to 0 on if_gnt or when if_req is low.
  - Saturates at STARVE_LIMIT.
- Tag pipeline: a MEM_LATENCY-deep shift register of {valid, owner}, where owner 0 = fetch and 1 = data.
  - Each cycle, stage 0 loads valid = (if_gnt || (d_gnt && d_we == 0)) and owner = d_gnt.
  - Stores push valid = 0 and never produce rvalid.
- Return path, from the last tag stage:
  - if_rvalid = valid && owner == 0.
  - d_rvalid = valid && owner == 1.
  - The matching rdata = mem_dout; the non-matching rdata = 0.
  - Responses return in issue order; there is no back-pressure on responses.
- Requesters hold req/addr/data stable until their grant is seen. A denied request is re-presented on the next cycle; the arbiter keeps no request queue.
- Reset (asynchronous assert, synchronous-to-clk release):
  - starve_cnt = 0 and all tag stages invalid.
  - if_rvalid and d_rvalid are 0 while rst_n is low.
  - Memory data returning after a mid-operation reset never raises rvalid.
- Boundary conditions:
  - Both requests in the same cycle: data wins unless force_if.
  - Back-to-back grants every cycle are legal; throughput is one access per cycle.
  - With STARVE_LIMIT = 0, fetch can be starved indefinitely by continuous d_req. The integration must guarantee this cannot happen.

Optional Feature:
- Macro: ARB_PERF_EN.
- When defined, add two outputs:
  - conflict_cnt (32-bit): increments each cycle if_req && d_req are both high.
  - force_cnt (32-bit): increments each cycle force_if && d_req are both high.
  - Both are cleared by rst_n and wrap modulo 2^32.
- When undefined, neither the ports nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x010, MEM_LATENCY = 1 -> if_gnt = 1 same cycle; mem_addr = 0x010, mem_we = 0; next cycle if_rvalid = 1 and if_rdata = mem_dout; d_rvalid stays 0.
- Conflict: if_req = d_req = 1, d_we = 0, d_addr = 0x020 -> d_gnt = 1, if_gnt = 0; next cycle d_rvalid = 1, if_rvalid = 0.
- Starvation, STARVE_LIMIT = 3: d_req and if_req high continuously -> d_gnt in cycles 0..2; cycle 3 if_gnt = 1, d_gnt = 0; cycle 4 d_gnt = 1 again.
- Store: d_req = 1, d_we = 4'b0011, d_wdata = 0xDEADBEEF -> mem_we = 0011, mem_din = 0xDEADBEEF; no rvalid on either side in the following MEM_LATENCY cycles.
- Latency and ordering, MEM_LATENCY = 3: alternating fetch/load grants in cycles 0..3 -> rvalid pattern if, d, if, d in cycles 3..6 with matching data routing.
- Reset mid-flight: grant a load in cycle 0, assert rst_n = 0 in cycle 1 -> no d_rvalid ever; with ARB_PERF_EN defined, conflict_cnt = 0 after reset.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around mem_port_arbiter.
// The arbiter uses the slave view; the surrounding pipeline/RAM use master.
interface mem_port_arbiter_if #(
  parameter int AWIDTH = 14,
  parameter int DWIDTH = 32
);
  logic              if_req;
  logic [AWIDTH-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DWIDTH-1:0] if_rdata;

  logic              d_req;
  logic [3:0]        d_we;
  logic [AWIDTH-1:0] d_addr;
  logic [DWIDTH-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DWIDTH-1:0] d_rdata;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_din;
  logic [DWIDTH-1:0] mem_dout;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-ported RAM with data priority, fetch
// anti-starvation and tagged read return. Define ARB_PERF_EN for perf counters.
module mem_port_arbiter #(
  parameter int AWIDTH       = 14,
  parameter int DWIDTH       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]         conflict_cnt,
  output logic [31:0]         force_cnt
`endif
);

  localparam int              SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0]          starve_cnt_q, starve_cnt_d;
  logic                   force_if;
  logic                   if_gnt;
  logic                   d_gnt;
  logic                   rd_issue;
  logic [MEM_LATENCY-1:0] vld_q;
  logic [MEM_LATENCY-1:0] own_q;
  logic                   ret_if;
  logic                   ret_d;

  always_comb begin
    force_if = (STARVE_LIMIT != 0) && (starve_cnt_q == STARVE_MAX);
    d_gnt    = bus.d_req && !force_if;
    if_gnt   = bus.if_req && (!bus.d_req || force_if);
    rd_issue = if_gnt || (d_gnt && (bus.d_we == 4'b0000));
  end

  assign bus.if_gnt = if_gnt;
  assign bus.d_gnt  = d_gnt;

  always_comb begin
    bus.mem_en   = if_gnt || d_gnt;
    bus.mem_we   = '0;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    if (d_gnt) begin
      bus.mem_we   = bus.d_we;
      bus.mem_addr = bus.d_addr;
      bus.mem_din  = bus.d_wdata;
    end else if (if_gnt) begin
      bus.mem_addr = bus.if_addr;
    end
  end

  // Counter holds at the limit; with STARVE_LIMIT = 0 it stays at zero.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.if_req || if_gnt)
      starve_cnt_d = '0;
    else if (starve_cnt_q != STARVE_MAX)
      starve_cnt_d = starve_cnt_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      vld_q        <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      vld_q[0]     <= rd_issue;
      for (int i = 1; i < MEM_LATENCY; i++)
        vld_q[i] <= vld_q[i-1];
    end
  end

  // Owner bits are only meaningful alongside a valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    own_q[0] <= d_gnt;
    for (int i = 1; i < MEM_LATENCY; i++)
      own_q[i] <= own_q[i-1];
  end

  always_comb begin
    ret_if        = vld_q[MEM_LATENCY-1] && !own_q[MEM_LATENCY-1];
    ret_d         = vld_q[MEM_LATENCY-1] &&  own_q[MEM_LATENCY-1];
    bus.if_rvalid = ret_if;
    bus.d_rvalid  = ret_d;
    bus.if_rdata  = ret_if ? bus.mem_dout : '0;
    bus.d_rdata   = ret_d  ? bus.mem_dout : '0;
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
      force_cnt    <= '0;
    end else begin
      if (bus.if_req && bus.d_req) conflict_cnt <= conflict_cnt + 32'd1;
      if (force_if && bus.d_req)   force_cnt    <= force_cnt + 32'd1;
    end
  end
`endif

endmodule
